// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian data memory behind a request/response handshake with WAIT_CYCLES wait states.
// Optional macro DMEM_ERR_EN: report misaligned/illegal accesses instead of silently aligning them.
module data_mem_responder #(
  parameter int WIDTH       = 32,
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t                 state_r, state_next_s;
  logic [3:0]             cnt_r, cnt_next_s;
  logic                   accept_s, enter_resp_s;
  logic                   ready_r, valid_r, err_r;
  logic [WIDTH-1:0]       rdata_r;
  logic                   we_r;
  logic [2:0]             funct3_r;
  logic [ADDR_BITS-1:0]   addr_r;
  logic [31:0]            wdata_r;
  logic [1:0]             size_s;
  logic                   sign_s, err_s;
  logic [ADDR_BITS-1:0]   idx_s;
  logic [3:0]             byte_en_s;
  logic [ADDR_BITS-1:0]   lane_addr_s [4];
  logic [31:0]            rd_word_r;
  logic [7:0]             mem_r [2**ADDR_BITS];
`ifdef DMEM_ERR_EN
  logic                   illegal_s;
`endif

  // Upper address bits are deliberately ignored so addresses wrap.
  logic unused_s;
  assign unused_s = ^req_addr[WIDTH-1:ADDR_BITS];

  function automatic logic [WIDTH-1:0] extend_load(input logic [31:0] word,
                                                   input logic [1:0] size,
                                                   input logic sgn);
    logic [WIDTH-1:0] res;
    case (size)
      2'd0:    res = {{(WIDTH-8){word[7] & sgn}}, word[7:0]};
      2'd1:    res = {{(WIDTH-16){word[15] & sgn}}, word[15:0]};
      default: res = WIDTH'(word);
    endcase
    return res;
  endfunction

  // Access decode from the latched request: size, signedness, error, byte lanes.
  always_comb begin
    size_s = 2'd2;
    sign_s = 1'b0;
`ifdef DMEM_ERR_EN
    illegal_s = 1'b0;
`endif
    case (funct3_r)
      3'b000:  begin size_s = 2'd0; sign_s = 1'b1; end
      3'b001:  begin size_s = 2'd1; sign_s = 1'b1; end
      3'b010:  begin size_s = 2'd2; sign_s = 1'b0; end
      3'b100:  begin size_s = 2'd0; sign_s = 1'b0; end
      3'b101:  begin size_s = 2'd1; sign_s = 1'b0; end
      default: begin
`ifdef DMEM_ERR_EN
        illegal_s = 1'b1;
`else
        size_s = 2'd2;
`endif
      end
    endcase
`ifdef DMEM_ERR_EN
    err_s = illegal_s | ((size_s == 2'd1) & addr_r[0]) |
            ((size_s == 2'd2) & (addr_r[1:0] != 2'b00));
    idx_s = addr_r;
`else
    err_s = 1'b0;
    idx_s = addr_r;
    if (size_s == 2'd1) begin
      idx_s[0] = 1'b0;
    end else if (size_s == 2'd2) begin
      idx_s[1:0] = 2'b00;
    end else begin
      idx_s = addr_r;
    end
`endif
    case (size_s)
      2'd0:    byte_en_s = 4'b0001;
      2'd1:    byte_en_s = 4'b0011;
      default: byte_en_s = 4'b1111;
    endcase
    for (int k = 0; k < 4; k++) begin
      lane_addr_s[k] = idx_s + ADDR_BITS'(k);
    end
  end

  // Next-state and wait counter.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid && ready_r) begin
          accept_s = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next_s = RESP;
          end else begin
            state_next_s = WAIT;
            cnt_next_s   = 4'(WAIT_CYCLES - 1);
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_next_s = RESP;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      RESP: begin
        if (valid_r && rsp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: state_next_s = IDLE;
    endcase
    enter_resp_s = (state_r != RESP) && (state_next_s == RESP);
  end

  // State register, request latch and registered response outputs.
  // rsp_valid trails RESP entry by one edge: that cycle turns the sampled word into rsp_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      rdata_r <= {WIDTH{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      ready_r <= (state_next_s == IDLE);
      valid_r <= (state_r == RESP) && (state_next_s == RESP);
      if (accept_s) begin
        we_r     <= req_we;
        funct3_r <= req_funct3;
        addr_r   <= req_addr[ADDR_BITS-1:0];
        wdata_r  <= req_wdata[31:0];
      end
      if (state_r == RESP && !valid_r) begin
        rdata_r <= (we_r || err_s) ? {WIDTH{1'b0}} : extend_load(rd_word_r, size_s, sign_s);
        err_r   <= err_s;
      end
    end
  end

  // Single-port storage, touched once per request on the edge entering RESP; never cleared.
  always_ff @(posedge clk) begin
    if (enter_resp_s && !rst) begin
      if (we_r) begin
        for (int k = 0; k < 4; k++) begin
          if (byte_en_s[k] && !err_s) begin
            mem_r[lane_addr_s[k]] <= wdata_r[8*k +: 8];
          end
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          rd_word_r[8*k +: 8] <= mem_r[lane_addr_s[k]];
        end
      end
    end
  end

  assign req_ready = ready_r;
  assign rsp_valid = valid_r;
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter WIDTH, default 32: data and address width.
REQ-002 Parameter ADDR_BITS, default 10: byte-address bits; storage is 2^ADDR_BITS bytes.
REQ-003 Parameter WAIT_CYCLES, default 2: wait states inserted before a response, range 0..15.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  CPU presents a load or store request.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_funct3  input  3  RV32I access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 req_addr  input  WIDTH  byte address.
REQ-011 req_wdata  input  WIDTH  store data, right-aligned.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  CPU consumes the response.
REQ-014 rsp_rdata  output  WIDTH  load result, extended to WIDTH; 0 for stores and errors.
REQ-015 rsp_err  output  1  request was misaligned or used an illegal funct3.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WAIT, and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1, and all req_* fields are latched on that edge.
REQ-018 On acceptance, the FSM SHALL go to WAIT with the counter loaded to WAIT_CYCLES-1, or go straight to RESP when WAIT_CYCLES=0.
REQ-019 In WAIT, the counter SHALL decrement by 1 per cycle and the FSM SHALL enter RESP on the edge where the counter equals 0.
REQ-020 rsp_valid SHALL rise exactly WAIT_CYCLES+1 edges after the acceptance edge.
REQ-021 In RESP, rsp_valid SHALL be 1; rsp_rdata and rsp_err SHALL hold stable until the edge where rsp_ready=1, and the FSM then returns to IDLE.
REQ-022 A new request SHALL NOT be accepted in the same cycle as a response handshake; minimum spacing between acceptances is WAIT_CYCLES+2 cycles.
REQ-023 Storage SHALL be little-endian, indexed by req_addr[ADDR_BITS-1:0]; upper address bits are ignored, so addresses wrap.
REQ-024 Stores SHALL commit on the edge entering RESP:
  - SB writes 1 byte, SH writes 2 bytes, SW writes 4 bytes, taken from the low bits of req_wdata;
  - other bytes are unchanged.
REQ-025 Loads SHALL sample storage on the edge entering RESP:
  - B and H are sign-extended;
  - BU and HU are zero-extended;
  - W is unmodified.
REQ-026 A load to the same address as the immediately preceding committed store SHALL return the stored data.
REQ-027 Storage SHALL be dual-use single-port: at most one access per request, with no read-during-write conflict.

Reset
REQ-028 While rst=1, state SHALL be IDLE and counter 0.
REQ-029 While rst=1, rsp_valid=0, rsp_rdata=0, and rsp_err=0.
REQ-030 While rst=1, req_ready=0; req_ready SHALL become 1 on the first cycle after rst falls.
REQ-031 Reset asserted in WAIT SHALL abort the request; a pending store SHALL NOT commit.
REQ-032 Reset asserted in RESP SHALL drop rsp_valid on the next edge.
REQ-033 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-034 Macro DMEM_ERR_EN defined: the block SHALL flag errors as follows:
  - H/HU with addr[0]=1 is misaligned;
  - W with addr[1:0]!=0 is misaligned;
  - funct3 011, 110, or 111 is illegal;
  - any of these sets rsp_err=1 and rsp_rdata=0, and a store does not write;
  - timing is unchanged.
REQ-035 Macro DMEM_ERR_EN undefined: the block SHALL behave as follows:
  - rsp_err is tied to 0;
  - address low bits are forced to alignment (addr[0] cleared for H, addr[1:0] cleared for W);
  - illegal funct3 values are treated as W.

Verification (WAIT_CYCLES=2)
REQ-036 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, and rsp_valid rises 3 edges after each acceptance.
REQ-037 After REQ-036: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
REQ-038 Hold rsp_ready=0 for 5 cycles during a LW response -> rsp_valid and rsp_rdata stay stable and req_ready stays 0 throughout; after rsp_ready=1, IDLE and req_ready=1 on the next cycle.
REQ-039 Address wrap: SW addr 0x410 data 0x12345678 with ADDR_BITS=10, then LW 0x010 -> 0x12345678.
REQ-040 With DMEM_ERR_EN: LW 0x11 -> rsp_err=1, rsp_rdata=0; SH 0x21 data 0xAAAA leaves LW 0x20 unchanged. Without the macro: LW 0x11 returns the word at 0x10.
REQ-041 SW 0x30 data 0x1, with rst pulsed during WAIT -> rsp_valid never rises and LW 0x30 returns the prior contents.
